// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// FSM state encoding and the quotient reported on a divide by zero.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left by one, trial-subtract
// the divisor from the shifted partial remainder and keep or restore it.
// Ports:
//   r_i       partial remainder in (WIDTH+1 bits)
//   q_i       quotient/dividend shift register in
//   divisor_i divisor
//   r_o       partial remainder out
//   q_o       quotient shift register out, new bit in LSB
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   r_o,
   output logic [WIDTH-1:0] q_o
);

   localparam int unsigned RW = WIDTH + 1;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-2:0] q_low;
   logic             unused_r_msb;

   // Partial remainder is always below the divisor, so its MSB is never needed.
   assign unused_r_msb = r_i[WIDTH];
   assign q_low        = q_i[WIDTH-2:0];

   always_comb begin
      r_sh  = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
      // Add/sub path in subtract mode: a + ~b + 1; MSB is the borrow.
      trial = r_sh + ~{1'b0, divisor_i} + RW'(1);
      if (trial[WIDTH]) begin
         r_o = r_sh;
         q_o = {q_low, 1'b0};
      end else begin
         r_o = trial;
         q_o = {q_low, 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multicycle unsigned restoring divider with start/busy/done handshake.
// One shift/trial-subtract step per clock; divide by zero reports an
// all-ones quotient with the dividend as remainder.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 request, accepted only in IDLE
//   dividend, divisor     operands, captured on an accepted start
//   quotient, remainder   registered results, held until next completion
//   busy                  high while the operation is in progress
//   done                  one-cycle pulse when results are valid
//   div_by_zero           registered flag, valid with done
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   div_state_e       state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH:0]   step_r;
   logic [WIDTH-1:0] step_q;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_i       (rem_q),
      .q_i       (quo_q),
      .divisor_i (dsr_q),
      .r_o       (step_r),
      .q_o       (step_q)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         cnt_q       <= '0;
         div0_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dsr_q       <= dsr_d;
         cnt_q       <= cnt_d;
         div0_q      <= div0_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dz_q        <= dz_d;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dsr_d       = dsr_q;
      cnt_d       = cnt_q;
      div0_d      = div0_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dz_d        = dz_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               dsr_d   = divisor;
               rem_d   = '0;
               quo_d   = dividend;
               div0_d  = (divisor == '0);
               dz_d    = 1'b0;
               // Zero divisor skips the iterations: one pass through CALC only.
               cnt_d   = (divisor == '0) ? '0 : CNT_W'(WIDTH);
               state_d = CALC;
            end
         end
         CALC: begin
            if (cnt_q != '0) begin
               rem_d = step_r;
               quo_d = step_q;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               quotient_d  = div0_q ? WIDTH'(DIV0_QUOTIENT) : quo_q;
               remainder_d = div0_q ? quo_q : rem_q[WIDTH-1:0];
               dz_d        = div0_q;
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CALC);
      done_d = (state_d == DONE);
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dz_q;

endmodule
